sub_32bit: RTL and testbench
============================

Name: sub_32bit

Overview:
- Registered 32-bit ripple-borrow subtractor: diff = op1 − op2 − cin, with borrow-out on cout.
- Built from a chain of 1-bit full subtractors.
- Result and borrow are captured in output registers on the clock.
- Used as the subtract datapath element in the arithmetic blocks; a debug bus exposes the internal borrow chain.

Parameters:
- WIDTH, 32, operand/result width in bits; all widths below scale with it.
- DEBUG_EN, 1, 1 = debug bus driven with the registered borrow chain; 0 = debug tied to all-zeros.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- op1  input  WIDTH  minuend.
- op2  input  WIDTH  subtrahend.
- cin  input  1  borrow-in (1 = subtract an extra 1).
- diff  output  WIDTH  registered difference, mod 2^WIDTH.
- cout  output  1  registered borrow-out from the MSB (1 = unsigned op1 < op2 + cin).
- debug  output  WIDTH  registered per-bit borrow-out chain; bit i = borrow out of bit i.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, diff, cout and debug all become 0. Reset is synchronous only; rst_n has no asynchronous effect.
- Reset mid-operation: the reset value wins on that edge. The result computed from inputs at that edge is discarded.
- Latency is 1 cycle. Inputs are sampled at each rising edge with rst_n=1; the outputs reflect those inputs after that edge. There is no handshake and no valid/ready.
- The block is fully pipelined: a new operand set is accepted every cycle.
- Outputs hold their value between edges, and change only on edges.
- Bit cell i computes:
  - d_i = a_i XOR b_i XOR bin_i
  - bout_i = (~a_i & b_i) | (~(a_i XOR b_i) & bin_i)
  - Chain: bin_0 = cin, bin_{i+1} = bout_i.
- diff = {d_{WIDTH-1}..d_0}; cout = bout_{WIDTH-1}; debug = {bout_{WIDTH-1}..bout_0}.
- Arithmetic is pure unsigned/two's-complement bit arithmetic.
  - No sign-magnitude interpretation: 0x80000007 is a bit pattern, not −7.
  - No overflow flag.
  - The result wraps modulo 2^WIDTH.
- Equivalent check: {cout, diff} = ({1'b0, op1} − {1'b0, op2} − cin) taken as WIDTH+1 bits. cout is the MSB of that result.
- Boundary: op1 = op2 with cin=1 gives diff all-ones and cout=1. op1 = 0 and op2 = all-ones with cin=1 gives diff=0 and cout=1.
- X on inputs propagates to the outputs; no X-masking is required.
- The borrow chain is combinational between the input and output flops. There is no carry-lookahead requirement.

Decomposition:
- No shared package needed. WIDTH is a local parameter; there are no typedefs.
- One sub-module: full_subtractor with ports a, b, bin, d, bout, instantiated WIDTH times in a generate loop.
- Top level holds the generate chain plus the output registers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with op1=0xFFFFFFFF, op2=1, cin=1 -> diff=0, cout=0, debug=0 after each edge. Release -> next edge diff=0xFFFFFFFD, cout=0.
- Basic: op1=7, op2=4, cin=0 -> diff=0x00000003, cout=0. Same with cin=1 -> diff=0x00000002, cout=0.
- Negative result: op1=4, op2=7, cin=0 -> diff=0xFFFFFFFD, cout=1. Same with cin=1 -> diff=0xFFFFFFFC, cout=1.
- MSB set: op1=0x80000007, op2=4, cin=0 -> diff=0x80000003, cout=0. Same with cin=1 -> diff=0x80000002, cout=0.
- Wrap/edge: op1=0, op2=0, cin=1 -> diff=0xFFFFFFFF, cout=1, debug=0xFFFFFFFF. Then op1=0x5, op2=0x5, cin=0 -> diff=0, cout=0, debug=0.
- Throughput/latency: apply a new vector every cycle for ≥1000 random cycles -> each output equals the reference model of the previous cycle's inputs. Assert rst_n=0 mid-stream for one edge -> outputs are 0 for exactly that cycle.

Source files
------------

// File: rtl/sub_32bit_full_subtractor.sv
// One-bit full subtractor cell: computes a - b - bin, producing the
// difference bit and the borrow out of this bit position.

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;

    // Difference bit is the parity of both operands and the incoming borrow.
    assign d = a_xor_b ^ bin;

    // Borrow out when the subtrahend bit exceeds the minuend bit, or when
    // they are equal and an incoming borrow has to be passed further up.
    assign bout = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/sub_32bit.sv
// Registered ripple-borrow subtractor: {cout, diff} = op1 - op2 - cin.
// The borrow ripples through a chain of one-bit cells between the input
// operands and the output flops; result, borrow-out and the per-bit borrow
// chain (debug view) are all captured on the same rising edge.

module sub_32bit #(
    parameter int WIDTH    = 32,
    parameter bit DEBUG_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
    output logic [WIDTH-1:0] diff,
    output logic             cout,
    output logic [WIDTH-1:0] debug
);

    // borrow[i] is the borrow into bit i; borrow[WIDTH] leaves the MSB.
    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff_d;
    logic             cout_d;
    logic [WIDTH-1:0] debug_d;

    logic [WIDTH-1:0] diff_q;
    logic             cout_q;
    logic [WIDTH-1:0] debug_q;

    assign borrow[0] = cin;

    // Ripple chain: each cell consumes the borrow produced by the cell below.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_subtractor u_fs (
                .a    (op1[gi]),
                .b    (op2[gi]),
                .bin  (borrow[gi]),
                .d    (diff_d[gi]),
                .bout (borrow[gi+1])
            );
        end
    endgenerate

    assign cout_d = borrow[WIDTH];

    // Debug view is the borrow out of every bit; it is held at zero when the
    // debug bus is disabled so the chain taps can be optimised away.
    generate
        if (DEBUG_EN) begin : g_debug_on
            assign debug_d = borrow[WIDTH:1];
        end else begin : g_debug_off
            assign debug_d = '0;
        end
    endgenerate

    // Output registers with synchronous active-low reset; reset wins over
    // whatever operands are presented on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_q  <= '0;
            cout_q  <= 1'b0;
            debug_q <= '0;
        end else begin
            diff_q  <= diff_d;
            cout_q  <= cout_d;
            debug_q <= debug_d;
        end
    end

    assign diff  = diff_q;
    assign cout  = cout_q;
    assign debug = debug_q;

endmodule

// File: tb/tb_sub_32bit.sv
// Self-checking bench for sub_32bit: directed boundary vectors followed by a
// long random stream with a one-edge reset injected mid-stream. Expected
// values come from plain wide arithmetic, not from a bit-cell model.

module tb_sub_32bit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         cin;
    logic [W-1:0] diff;
    logic         cout;
    logic [W-1:0] debug;

    int cmp_cnt = 0;
    int err_cnt = 0;

    sub_32bit #(
        .WIDTH    (W),
        .DEBUG_EN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .op1   (op1),
        .op2   (op2),
        .cin   (cin),
        .diff  (diff),
        .cout  (cout),
        .debug (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full-width unsigned result: top bit is the borrow out of the MSB.
    function automatic logic [W:0] ref_sub(logic [W-1:0] a, logic [W-1:0] b, logic c);
        logic [W:0] r;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
        return r;
    endfunction

    // Borrow out of bit i happens exactly when the low i+1 bits of a are
    // smaller, as an unsigned number, than the low i+1 bits of b plus c.
    function automatic logic [W-1:0] ref_borrows(logic [W-1:0] a, logic [W-1:0] b, logic c);
        logic [W-1:0] r;
        longint unsigned mask, la, lb;
        r = '0;
        for (int i = 0; i < W; i++) begin
            mask = (64'd1 << (i + 1)) - 64'd1;
            la   = longint'(a) & mask;
            lb   = (longint'(b) & mask) + longint'(c);
            r[i] = (la < lb);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one operand set, clock it in, then check all outputs.
    task automatic step(input string tag, input logic rst_val,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0]   r;
        logic [W-1:0] bw;
        rst_n = rst_val;
        op1   = a;
        op2   = b;
        cin   = c;
        @(posedge clk);
        #1;
        if (!rst_val) begin
            r  = '0;
            bw = '0;
        end else begin
            r  = ref_sub(a, b, c);
            bw = ref_borrows(a, b, c);
        end
        check({tag, ".diff"},  diff,  r[W-1:0]);
        check({tag, ".cout"},  {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, r[W]});
        check({tag, ".debug"}, debug, bw);
        $display("step %-10s rst_n=%0b op1=%h op2=%h cin=%0b -> diff=%h cout=%0b debug=%h",
                 tag, rst_val, a, b, c, diff, cout, debug);
    endtask

    initial begin
        logic [W-1:0] held_diff;
        logic [W-1:0] held_debug;
        logic         held_cout;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic         rr;

        rst_n = 1'b0;
        op1   = 32'hFFFF_FFFF;
        op2   = 32'h0000_0001;
        cin   = 1'b1;

        // Reset held for two edges: outputs zero regardless of operands.
        step("reset0", 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        step("reset1", 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        check("reset.diff_const", diff, 32'h0);
        step("release", 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1);
        check("release.diff_const", diff, 32'hFFFF_FFFD);

        // Directed cases with literal expectations cross-checked too.
        step("basic0", 1'b1, 32'd7, 32'd4, 1'b0);
        check("basic0.lit", diff, 32'h0000_0003);
        step("basic1", 1'b1, 32'd7, 32'd4, 1'b1);
        check("basic1.lit", diff, 32'h0000_0002);
        step("neg0", 1'b1, 32'd4, 32'd7, 1'b0);
        check("neg0.lit", diff, 32'hFFFF_FFFD);
        check("neg0.cout_lit", {31'b0, cout}, 32'h1);
        step("neg1", 1'b1, 32'd4, 32'd7, 1'b1);
        check("neg1.lit", diff, 32'hFFFF_FFFC);
        step("msb0", 1'b1, 32'h8000_0007, 32'd4, 1'b0);
        check("msb0.lit", diff, 32'h8000_0003);
        step("msb1", 1'b1, 32'h8000_0007, 32'd4, 1'b1);
        check("msb1.lit", diff, 32'h8000_0002);
        step("wrap", 1'b1, 32'd0, 32'd0, 1'b1);
        check("wrap.lit", debug, 32'hFFFF_FFFF);
        step("equal", 1'b1, 32'h5, 32'h5, 1'b0);
        check("equal.lit", debug, 32'h0);
        step("eq_cin", 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1);
        check("eq_cin.lit", diff, 32'hFFFF_FFFF);
        step("zero_max", 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1);
        check("zero_max.lit", {31'b0, cout}, 32'h1);

        // Outputs must not follow input changes between edges.
        held_diff  = diff;
        held_cout  = cout;
        held_debug = debug;
        op1 = 32'hDEAD_BEEF;
        op2 = 32'h0BAD_F00D;
        cin = 1'b0;
        #3;
        check("hold.diff",  diff,  held_diff);
        check("hold.cout",  {31'b0, cout}, {31'b0, held_cout});
        check("hold.debug", debug, held_debug);

        // Random back-to-back stream with a single reset edge in the middle.
        for (int n = 0; n < 1200; n++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(1, 0));
            if (n % 7 == 0) rb = ra;
            if (n % 11 == 0) rb = ra + 32'd1;
            rr = (n == 600) ? 1'b0 : 1'b1;
            step(rr ? "rand" : "rand_rst", rr, ra, rb, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
